clock_ratio_detector: RTL and testbench
=======================================

Name: clock_ratio_detector

Overview:
- Receive-side companion to the clock divider.
- Samples a slow, divided clock (or any periodic level signal) in the fast clk_in domain.
- Measures its period in clk_in cycles, declares lock after repeated identical periods, and flags loss of activity.
- Used to check divider ratios in-system and to qualify the divided clock before downstream logic trusts it.

Parameters:
- CNT_W, 16, width of period counter and period/high-time outputs.
- LOCK_CNT, 4, consecutive equal periods required to assert locked (range 2..255).
- TIMEOUT, 1000, clk_in cycles without a rising edge before timeout; must be < 2^CNT_W.

Ports:
- clk_in  input  1  fast reference clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- sig_in  input  1  slow divided clock, asynchronous to nothing but treated as level input.
- period_out  output  CNT_W  last measured period in clk_in cycles.
- period_valid  output  1  one-cycle pulse when period_out updates.
- locked  output  1  LOCK_CNT consecutive identical periods seen.
- timeout  output  1  one-cycle pulse on loss of activity.
- high_out  output  CNT_W  high-time of last period (see Optional Feature).

Behaviour:
- Reset, sampled on posedge clk_in with rst=0:
  - Outputs: period_out=0, period_valid=0, locked=0, timeout=0, high_out=0.
  - Internal: sync flops=0, state=SEEK, cnt=0, match_cnt=0.
- Input path: sig_in passes through 2-flop synchronizer s1->s2; s3 is a delayed copy of s2. rise = s2 & ~s3.
  - Fixed latency: 3 clk_in edges from sig_in rising to the rise cycle.
- Counter cnt:
  - Loads 1 in the cycle after a rise.
  - Otherwise increments, saturating at TIMEOUT.
  - With rises P cycles apart, cnt==P on the second rise.
- States:
  - SEEK: no reference edge yet.
    - rise -> MEASURE; cnt=1; no period output.
  - MEASURE: on rise:
    - period_out<=cnt; period_valid=1 next cycle.
    - If cnt==previous period: match_cnt++. Otherwise match_cnt<=1.
    - If the new match_cnt==LOCK_CNT -> LOCKED; locked=1 in the same cycle period_valid asserts.
  - LOCKED: on rise:
    - Period captured and period_valid pulsed as in MEASURE.
    - If cnt differs from the stored period: locked<=0, match_cnt<=1 -> MEASURE.
- Timeout:
  - Condition: in MEASURE or LOCKED, cnt==TIMEOUT and no rise this cycle.
  - Action: timeout pulses 1 cycle; locked<=0; period_out<=0; high_out<=0; match_cnt<=0 -> SEEK.
- Priority:
  - rise and cnt==TIMEOUT in the same cycle: rise wins; period TIMEOUT is captured; no timeout.
  - rst=0 overrides everything.
- Reset mid-measurement: all state cleared; the first rise after release only re-enters MEASURE.
- Sync skew: sig_in held constant -> no rise; period_valid never asserts.
- First captured period after SEEK never counts as a match (match_cnt=1).

Optional Feature:
- Macro: CLOCK_RATIO_DUTY_MEAS_EN.
- Defined:
  - hcnt counts cycles with s2=1 since the last rise; it loads 1 on rise.
  - On each rise, high_out<=hcnt together with period_out.
  - Lock additionally requires high time equal to the previous high time.
- Undefined:
  - high_out is tied to 0.
  - No hcnt logic; lock uses period only.

Test Plan:
- Reset: rst=0 for 2 edges with sig_in toggling -> all outputs 0, no period_valid during reset.
- Divide-by-4: sig_in 2 cycles high / 2 low, 8 periods, LOCK_CNT=4 -> period_out=4 on each valid pulse; locked=1 with the 4th valid pulse; high_out=2 with DUTY_MEAS_EN.
- Ratio change: after lock at 4, switch to 3 high / 3 low -> next valid shows period_out=6; locked drops that cycle; relocks after 3 further period-6 captures.
- Stall: lock at 4, then hold sig_in=0 -> timeout pulses exactly TIMEOUT cycles after last cnt load; locked=0; period_out=0; the next two rises produce one period_valid only.
- Boundary: rises spaced exactly TIMEOUT cycles apart -> period_out=TIMEOUT, timeout never asserts.
- Mid-op reset: rst=0 one cycle while LOCKED -> outputs cleared next edge; first rise after release produces no period_valid.

Source files
------------

// File: rtl/clock_ratio_detector.sv
// Measures the period of a slow level signal in clk_in cycles, declares lock after
// LOCK_CNT identical periods and pulses timeout on loss of activity. Define
// CLOCK_RATIO_DUTY_MEAS_EN to also measure high time and require it for lock.
module clock_ratio_detector #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [CNT_W-1:0] high_out
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [7:0]       LockVal    = 8'(LOCK_CNT);

    typedef enum logic [1:0] {StSeek, StMeasure, StLocked} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       match_cnt;
    logic             rise;
    logic             at_limit;
    logic             same;
    logic [7:0]       match_next;

`ifdef CLOCK_RATIO_DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] high_q;

    assign high_out = high_q;
    assign same     = (cnt == period_out) && (hcnt == high_q);
`else
    assign high_out = '0;
    assign same     = (cnt == period_out);
`endif

    assign rise       = s2 & ~s3;
    assign at_limit   = (cnt == TimeoutVal);
    // period_out is 0 after reset/timeout, so the first capture can never match.
    assign match_next = same ? match_cnt + 8'd1 : 8'd1;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= StSeek;
            cnt          <= '0;
            match_cnt    <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
`ifdef CLOCK_RATIO_DUTY_MEAS_EN
            hcnt         <= '0;
            high_q       <= '0;
`endif
        end else begin
            s1           <= sig_in;
            s2           <= s1;
            s3           <= s2;
            period_valid <= 1'b0;
            timeout      <= 1'b0;

            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (!at_limit) begin
                cnt <= cnt + CNT_W'(1);
            end

`ifdef CLOCK_RATIO_DUTY_MEAS_EN
            if (rise) begin
                hcnt <= CNT_W'(1);
            end else if (s2 && (hcnt != '1)) begin
                hcnt <= hcnt + CNT_W'(1);
            end
`endif

            case (state)
                StSeek: begin
                    if (rise) state <= StMeasure;
                end
                StMeasure, StLocked: begin
                    if (rise) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
`ifdef CLOCK_RATIO_DUTY_MEAS_EN
                        high_q       <= hcnt;
`endif
                        if (state == StMeasure) begin
                            match_cnt <= match_next;
                            if (match_next == LockVal) begin
                                state  <= StLocked;
                                locked <= 1'b1;
                            end
                        end else if (!same) begin
                            locked    <= 1'b0;
                            match_cnt <= 8'd1;
                            state     <= StMeasure;
                        end
                    end else if (at_limit) begin
                        // Rise has priority above, so a period of exactly TIMEOUT is kept.
                        timeout    <= 1'b1;
                        locked     <= 1'b0;
                        period_out <= '0;
                        match_cnt  <= '0;
                        state      <= StSeek;
`ifdef CLOCK_RATIO_DUTY_MEAS_EN
                        high_q     <= '0;
`endif
                    end
                end
                default: state <= StSeek;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Scoreboard bench for clock_ratio_detector: expected captures are queued as each
// rising edge of sig_in is driven and popped on every period_valid pulse.
module tb_clock_ratio_detector;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned LOCK  = 4;
    localparam int unsigned T     = 40;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    logic [CNT_W-1:0] high_out;

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        logic             lk;
    } exp_t;

    exp_t q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_to       = 0;
    int   cyc        = 0;
    int   last_valid = 0;

    clock_ratio_detector #(
        .CNT_W   (CNT_W),
        .LOCK_CNT(LOCK),
        .TIMEOUT (T)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .sig_in      (sig_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout),
        .high_out    (high_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard pop on every valid pulse; timeout pulse checked against last capture.
    always @(negedge clk_in) begin
        exp_t e;
        if (period_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d locked=%0d, no capture expected",
                         period_out, high_out, locked);
            end else begin
                e = q.pop_front();
                if ({period_out, high_out, locked} !== {e.p, e.h, e.lk}) begin
                    n_fail++;
                    $display("FAIL capture: got period=%0d high=%0d locked=%0d, want period=%0d high=%0d locked=%0d",
                             period_out, high_out, locked, e.p, e.h, e.lk);
                end
            end
            last_valid = cyc;
        end
        if (timeout) begin
            n_to++;
            n_checks++;
            if ((cyc - last_valid) != int'(T) || locked !== 1'b0 || period_out !== '0 ||
                high_out !== '0) begin
                n_fail++;
                $display("FAIL timeout_pulse: got delay=%0d locked=%0d period=%0d high=%0d, want delay=%0d and zeros",
                         cyc - last_valid, locked, period_out, high_out, T);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wave(input int h, input int l);
        sig_in = 1'b1;
        step(h);
        sig_in = 1'b0;
        step(l);
    endtask

    task automatic push(input int p, input int h, input logic lk);
        exp_t e;
        e.p = CNT_W'(p);
`ifdef CLOCK_RATIO_DUTY_MEAS_EN
        e.h = CNT_W'(h);
`else
        e.h = '0;
`endif
        e.lk = lk;
        q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({period_out, period_valid, locked, timeout, high_out} !== '0) begin
            n_fail++;
            $display("FAIL %s: got period=%0d valid=%0d locked=%0d timeout=%0d high=%0d, want all 0",
                     name, period_out, period_valid, locked, timeout, high_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sig_in = ~sig_in;
            step(1);
            check_idle("reset_hold");
        end
        sig_in = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        check_idle("reset_release");
    endtask

    task automatic test_div4();
        wave(2, 2);
        for (int i = 1; i <= 8; i++) begin
            push(4, 2, i >= int'(LOCK));
            wave(2, 2);
        end
        n_checks++;
        if (locked !== 1'b1 || period_out !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL div4_lock: got locked=%0d period=%0d, want locked=1 period=4",
                     locked, period_out);
        end
    endtask

    task automatic test_ratio_change();
        push(4, 2, 1'b1);
        wave(3, 3);
        for (int i = 1; i <= 4; i++) begin
            push(6, 3, i == 4);
            wave(3, 3);
        end
        n_checks++;
        if (locked !== 1'b1 || period_out !== CNT_W'(6)) begin
            n_fail++;
            $display("FAIL ratio_relock: got locked=%0d period=%0d, want locked=1 period=6",
                     locked, period_out);
        end
    endtask

    task automatic test_stall();
        int base;
        base   = n_to;
        sig_in = 1'b0;
        for (int i = 0; i < int'(T) + 20; i++) begin
            if (n_to != base) break;
            step(1);
        end
        step(5);
        n_checks++;
        if (n_to != base + 1 || locked !== 1'b0 || period_out !== '0) begin
            n_fail++;
            $display("FAIL stall: got timeouts=%0d locked=%0d period=%0d, want timeouts=1 locked=0 period=0",
                     n_to - base, locked, period_out);
        end
    endtask

    task automatic test_boundary();
        int base;
        base = n_to;
        wave(2, int'(T) - 2);
        for (int i = 1; i <= 4; i++) begin
            push(int'(T), 2, i == 4);
            wave(2, int'(T) - 2);
        end
        n_checks++;
        if (n_to != base || locked !== 1'b1 || period_out !== CNT_W'(T)) begin
            n_fail++;
            $display("FAIL boundary: got timeouts=%0d locked=%0d period=%0d, want timeouts=0 locked=1 period=%0d",
                     n_to - base, locked, period_out, T);
        end
    endtask

    task automatic test_midop_reset();
        push(int'(T), 2, 1'b1);
        wave(2, 6);
        rst = 1'b0;
        step(1);
        check_idle("midop_reset");
        rst = 1'b1;
        wave(2, 2);
        push(4, 2, 1'b0);
        wave(2, 2);
        step(8);
        n_checks++;
        if (q.size() != 0 || locked !== 1'b0 || period_out !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL midop_rearm: got pending=%0d locked=%0d period=%0d, want pending=0 locked=0 period=4",
                     q.size(), locked, period_out);
        end
    endtask

    initial begin
        @(posedge clk_in);
        #1;
        test_reset();
        test_div4();
        test_ratio_change();
        test_stall();
        test_boundary();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
